// File: rtl/product_arbiter_if.sv
// Handshake and operand bus between the requesters, the shared product stage
// and the product_arbiter controller.
interface product_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        ip_req;
    logic [NUM_REQ*DATA_W-1:0] ip_a;
    logic [NUM_REQ*DATA_W-1:0] ip_b;
    logic [NUM_REQ-1:0]        op_grant;
    logic [DATA_W-1:0]         op_mul_a;
    logic [DATA_W-1:0]         op_mul_b;
    logic [DATA_W-1:0]         ip_mul_result;
    logic [DATA_W-1:0]         op_result;
    logic [ID_W-1:0]           op_result_id;
    logic                      op_result_valid;
    logic                      ip_result_ready;
    logic                      op_busy;

    modport slave (
        input  ip_req, ip_a, ip_b, ip_mul_result, ip_result_ready,
        output op_grant, op_mul_a, op_mul_b, op_result, op_result_id,
               op_result_valid, op_busy
    );

    modport master (
        output ip_req, ip_a, ip_b, ip_mul_result, ip_result_ready,
        input  op_grant, op_mul_a, op_mul_b, op_result, op_result_id,
               op_result_valid, op_busy
    );
endinterface

// File: rtl/product_arbiter.sv
// Round-robin arbiter sharing one negedge-registered product stage among
// NUM_REQ requesters; the tagged result is held until the consumer accepts it.
module product_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 12,
    parameter int MUL_LATENCY = 1,
    parameter int ID_W        = 2
) (
    input  logic             ip_clock,
    input  logic             ip_reset,
    product_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a request; rr_ptr is the first index scanned
    // WAIT  | winner operands on the multiplier, counting MUL_LATENCY edges
    // DONE  | result valid and held until ip_result_ready
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [DATA_W-1:0]  mul_a_q;
    logic [DATA_W-1:0]  mul_b_q;
    logic [DATA_W-1:0]  result_q;
    logic [ID_W-1:0]    result_id_q;
    logic               valid_q;
    logic               busy_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    scan_id;
    logic [ID_W:0]      scan_sum;
    logic [DATA_W-1:0]  win_a;
    logic [DATA_W-1:0]  win_b;

    // Scanning from the farthest offset back to rr_ptr lets the nearest request win.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_sum  = '0;
        scan_id   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_id = scan_sum[ID_W-1:0];
            if (bus.ip_req[scan_id]) begin
                win_found = 1'b1;
                win_id    = scan_id;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = bus.ip_a[i*DATA_W +: DATA_W];
                win_b = bus.ip_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge ip_clock or negedge ip_reset) begin
        if (!ip_reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            grant_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        mul_a_q     <= win_a;
                        mul_b_q     <= win_b;
                        grant_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                        result_id_q <= win_id;
                        cnt_q       <= CNT_W'(MUL_LATENCY);
                        state_q     <= WAIT;
                        busy_q      <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= bus.ip_mul_result;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ip_result_ready) begin
                        valid_q  <= 1'b0;
                        rr_ptr_q <= (result_id_q == ID_W'(NUM_REQ - 1)) ? '0 : result_id_q + 1'b1;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_grant        = grant_q;
    assign bus.op_mul_a        = mul_a_q;
    assign bus.op_mul_b        = mul_b_q;
    assign bus.op_result       = result_q;
    assign bus.op_result_id    = result_id_q;
    assign bus.op_result_valid = valid_q;
    assign bus.op_busy         = busy_q;
endmodule

// File: tb/tb_product_arbiter.sv
// Bench for product_arbiter: vector table plus scoreboard for results, and
// hand-written sequences for backpressure, continuous requests, reset and latency 3.
module tb_product_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;
    localparam int ID_W    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    product_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();
    product_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus3 ();

    product_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MUL_LATENCY(1), .ID_W(ID_W)) u_dut (
        .ip_clock (clk),
        .ip_reset (rst_n),
        .bus      (bus)
    );

    product_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MUL_LATENCY(3), .ID_W(ID_W)) u_dut3 (
        .ip_clock (clk),
        .ip_reset (rst_n),
        .bus      (bus3)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_mul(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] p;
        p = {12'd0, a} * {12'd0, b};
        return p[11:0];
    endfunction

    function automatic logic [11:0] op_of(input logic [47:0] v, input int id);
        logic [47:0] s;
        s = v >> (12 * id);
        return s[11:0];
    endfunction

    function automatic int oh2id(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Negedge-registered product stage for the latency-1 instance.
    always @(negedge clk) bus.ip_mul_result <= model_mul(bus.op_mul_a, bus.op_mul_b);

    // Product stage for the latency-3 instance changes every cycle.
    logic [11:0] negc = 12'd0;
    always @(negedge clk) negc <= negc + 12'd1;
    function automatic logic [11:0] f3(input logic [11:0] x);
        return 12'(x * 12'd13 + 12'd5);
    endfunction
    assign bus3.ip_mul_result = f3(negc);

    typedef struct packed {
        logic [1:0]  id;
        logic [11:0] res;
    } sb_t;
    sb_t  sb[$];
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        sb_t e;
        int  gid;
        if (!rst_n) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.op_grant != 4'b0) begin
                gid   = oh2id(bus.op_grant);
                e.id  = 2'(gid);
                e.res = model_mul(op_of(bus.ip_a, gid), op_of(bus.ip_b, gid));
                sb.push_back(e);
            end
            if (bus.op_result_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL sb_unexpected: got=valid_result expected=no_result at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", 32'(bus.op_result), 32'(e.res));
                    chk("sb_result_id", 32'(bus.op_result_id), 32'(e.id));
                end
            end
            prev_valid = bus.op_result_valid;
        end
    end

    typedef struct packed {
        logic [3:0]        req;
        logic [3:0][11:0]  a;
        logic [3:0][11:0]  b;
        logic [1:0]        exp_id;
        logic [3:0]        exp_grant;
    } vec_t;
    vec_t vt[8];

    task automatic run_txn(input vec_t v);
        int n;
        #1;
        bus.ip_a = v.a;
        bus.ip_b = v.b;
        bus.ip_req = v.req;
        bus.ip_result_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.op_grant == 4'b0 && n < 6);
        chk("grant", 32'(bus.op_grant), 32'(v.exp_grant));
        chk("grant_latency", n, 1);
        chk("mul_a", 32'(bus.op_mul_a), 32'(v.a[v.exp_id]));
        chk("mul_b", 32'(bus.op_mul_b), 32'(v.b[v.exp_id]));
        chk("busy_wait", 32'(bus.op_busy), 1);
        #1 bus.ip_req = 4'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.op_result_valid && n < 8);
        chk("valid_latency", n, 1);
        chk("grant_pulse", 32'(bus.op_grant), 0);
        chk("mul_a_hold", 32'(bus.op_mul_a), 32'(v.a[v.exp_id]));
        #1 bus.ip_result_ready = 1'b1;
        @(negedge clk);
        chk("valid_fall", 32'(bus.op_result_valid), 0);
        chk("busy_idle", 32'(bus.op_busy), 0);
        #1 bus.ip_result_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          gid_rec[5];
        int          cyc_rec[5];
        int          k;
        logic [11:0] hold_res;
        logic [1:0]  hold_id;
        logic        seen_valid;
        logic [11:0] base;

        vt[0] = '{4'b0100, {12'd11, 12'd5, 12'd9, 12'd7},   {12'd2, 12'd3, 12'd4, 12'd6},   2'd2, 4'b0100};
        vt[1] = '{4'b1001, {12'd100, 12'd0, 12'd0, 12'd33}, {12'd50, 12'd0, 12'd0, 12'd21}, 2'd3, 4'b1000};
        vt[2] = '{4'b1001, {12'd100, 12'd0, 12'd0, 12'd33}, {12'd50, 12'd0, 12'd0, 12'd21}, 2'd0, 4'b0001};
        vt[3] = '{4'b0001, {12'd0, 12'd0, 12'd0, 12'd4095}, {12'd0, 12'd0, 12'd0, 12'd4095}, 2'd0, 4'b0001};
        vt[4] = '{4'b1110, {12'd1, 12'd2, 12'd3, 12'd0},    {12'd4, 12'd5, 12'd6, 12'd0},   2'd1, 4'b0010};
        vt[5] = '{4'b0011, {12'd0, 12'd0, 12'd10, 12'd20},  {12'd0, 12'd0, 12'd30, 12'd40}, 2'd0, 4'b0001};
        vt[6] = '{4'b1111, {12'd8, 12'd7, 12'd6, 12'd5},    {12'd9, 12'd9, 12'd9, 12'd9},   2'd1, 4'b0010};
        vt[7] = '{4'b1000, {12'd64, 12'd0, 12'd0, 12'd0},   {12'd64, 12'd0, 12'd0, 12'd0},  2'd3, 4'b1000};

        bus.ip_req = '0;  bus.ip_a = '0;  bus.ip_b = '0;  bus.ip_result_ready = 1'b0;
        bus3.ip_req = '0; bus3.ip_a = '0; bus3.ip_b = '0; bus3.ip_result_ready = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(bus.op_grant), 0);
        chk("rst_mul_a", 32'(bus.op_mul_a), 0);
        chk("rst_mul_b", 32'(bus.op_mul_b), 0);
        chk("rst_result", 32'(bus.op_result), 0);
        chk("rst_result_id", 32'(bus.op_result_id), 0);
        chk("rst_valid", 32'(bus.op_result_valid), 0);
        chk("rst_busy", 32'(bus.op_busy), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.op_busy), 0);
        chk("idle_grant", 32'(bus.op_grant), 0);

        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Backpressure with another requester pending during DONE.
        #1;
        bus.ip_a = {12'd0, 12'd0, 12'd25, 12'd12};
        bus.ip_b = {12'd0, 12'd0, 12'd4, 12'd11};
        bus.ip_req = 4'b0010;
        @(negedge clk);
        chk("bp_grant", 32'(bus.op_grant), 32'h2);
        #1 bus.ip_req = 4'b0001;
        @(negedge clk);
        chk("bp_valid", 32'(bus.op_result_valid), 1);
        hold_res = bus.op_result;
        hold_id  = bus.op_result_id;
        repeat (5) begin
            @(negedge clk);
            chk("bp_result_hold", 32'(bus.op_result), 32'd100);
            chk("bp_id_hold", 32'(bus.op_result_id), 32'(hold_id));
            chk("bp_no_grant", 32'(bus.op_grant), 0);
            chk("bp_busy", 32'(bus.op_busy), 1);
            chk("bp_valid_hold", 32'(bus.op_result_valid), 1);
        end
        chk("bp_first_result", 32'(hold_res), 32'd100);
        #1 bus.ip_result_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_fall", 32'(bus.op_result_valid), 0);
        chk("bp_grant_gap", 32'(bus.op_grant), 0);
        #1 bus.ip_result_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_grant", 32'(bus.op_grant), 32'h1);
        #1 bus.ip_req = 4'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.op_result_valid && n < 8);
        chk("bp_next_valid", 32'(bus.op_result_valid), 1);
        #1 bus.ip_result_ready = 1'b1;
        @(negedge clk);
        #1 bus.ip_result_ready = 1'b0;

        // Continuous requests from everyone, ready tied high, pointer restarted at 0.
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        bus.ip_a = {12'd40, 12'd30, 12'd20, 12'd10};
        bus.ip_b = {12'd4, 12'd3, 12'd2, 12'd1};
        bus.ip_req = 4'b1111;
        bus.ip_result_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin gid_rec[i] = -1; cyc_rec[i] = 0; end
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.op_grant != 4'b0 && k < 5) begin
                gid_rec[k] = oh2id(bus.op_grant);
                cyc_rec[k] = c;
                k++;
            end
        end
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(gid_rec[i]), 32'(i % 4));
        for (int i = 1; i < 5; i++) chk("rr_gap", 32'(cyc_rec[i] - cyc_rec[i-1]), 32'd3);
        #1 bus.ip_req = 4'b0;
        repeat (5) @(negedge clk);
        chk("rr_drain_busy", 32'(bus.op_busy), 0);
        #1 bus.ip_result_ready = 1'b0;

        // Reset during WAIT aborts the transaction without a clock edge.
        bus.ip_a = {12'd0, 12'd5, 12'd0, 12'd0};
        bus.ip_b = {12'd0, 12'd3, 12'd0, 12'd0};
        bus.ip_req = 4'b0100;
        @(negedge clk);
        chk("abort_grant", 32'(bus.op_grant), 32'h4);
        #1 rst_n = 1'b0;
        bus.ip_req = 4'b0;
        #1;
        chk("abort_grant_clr", 32'(bus.op_grant), 0);
        chk("abort_mul_a", 32'(bus.op_mul_a), 0);
        chk("abort_mul_b", 32'(bus.op_mul_b), 0);
        chk("abort_result", 32'(bus.op_result), 0);
        chk("abort_result_id", 32'(bus.op_result_id), 0);
        chk("abort_valid", 32'(bus.op_result_valid), 0);
        chk("abort_busy", 32'(bus.op_busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.op_result_valid;
        end
        chk("abort_no_valid", 32'(seen_valid), 0);

        // Latency-3 instance samples the product present at the third edge.
        #1;
        bus3.ip_a = {36'd0, 12'd77};
        bus3.ip_b = {36'd0, 12'd3};
        bus3.ip_req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (bus3.op_grant == 4'b0 && n < 6);
        base = negc;
        chk("l3_grant", 32'(bus3.op_grant), 32'h1);
        #1 bus3.ip_req = 4'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("l3_mul_a_hold", 32'(bus3.op_mul_a), 32'd77);
        end while (!bus3.op_result_valid && n < 10);
        chk("l3_latency", n, 3);
        chk("l3_result", 32'(bus3.op_result), 32'(f3(base + 12'd3)));
        chk("l3_result_id", 32'(bus3.op_result_id), 0);
        #1 bus3.ip_result_ready = 1'b1;
        @(negedge clk);
        chk("l3_valid_fall", 32'(bus3.op_result_valid), 0);
        #1 bus3.ip_result_ready = 1'b0;

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
